// File: rtl/seq_player.sv
// seq_player: plays entries 0..last of a 16x4 synchronous RAM on leds, each
// shown for HOLD_CYCLES then blanked for GAP_CYCLES, then pulses done.
// Latency: 2+HOLD_CYCLES+GAP_CYCLES cycles per entry; start is ignored while busy.
//
// Ports:
//   clk, rst_n  - system clock, asynchronous active-low reset
//   start, stop - play request (taken only in IDLE), abort request (any busy state)
//   last        - index of the final entry, latched when start is accepted
//   ram_addr    - read address to the external RAM (driven from idx)
//   ram_q       - RAM read data, valid one cycle after ram_addr is sampled
//   leds        - displayed entry, 0 when blank
//   busy, done  - not idle; one-cycle pulse on completed playback
module seq_player #(
  parameter int HOLD_CYCLES = 50000000,
  parameter int GAP_CYCLES  = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] last,
  output logic [3:0] ram_addr,
  input  logic [3:0] ram_q,
  output logic [3:0] leds,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHOW  = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Terminal counts: the timer runs 0..N-1, so an interval lasts exactly N cycles.
  localparam logic [25:0] HOLD_END = 26'(HOLD_CYCLES - 1);
  localparam logic [25:0] GAP_END  = 26'(GAP_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  idx, idx_nxt;
  logic [3:0]  last_reg, last_nxt;
  logic [3:0]  data_reg, data_nxt;
  logic [25:0] timer, timer_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= 4'd0;
      last_reg <= 4'd0;
      data_reg <= 4'd0;
      timer    <= 26'd0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      last_reg <= last_nxt;
      data_reg <= data_nxt;
      timer    <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    last_nxt  = last_reg;
    data_nxt  = data_reg;
    timer_nxt = timer;

    case (state)
      IDLE: begin
        // start together with stop is treated as no request
        if (start && !stop) begin
          last_nxt  = last;
          idx_nxt   = 4'd0;
          state_nxt = FETCH;
        end
      end
      FETCH: state_nxt = LOAD;   // RAM registers ram_addr at the end of this cycle
      LOAD: begin
        data_nxt  = ram_q;
        timer_nxt = 26'd0;
        state_nxt = SHOW;
      end
      SHOW: begin
        if (timer == HOLD_END) begin
          timer_nxt = 26'd0;
          state_nxt = GAP;
        end else begin
          timer_nxt = timer + 26'd1;
        end
      end
      GAP: begin
        if (timer == GAP_END) begin
          timer_nxt = 26'd0;
          // Compare before incrementing so idx never wraps when last_reg is 15
          if (idx == last_reg) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 4'd1;
            state_nxt = FETCH;
          end
        end else begin
          timer_nxt = timer + 26'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Abort overrides every other transition
    if (stop && (state != IDLE)) begin
      state_nxt = IDLE;
      timer_nxt = 26'd0;
    end
  end

  // Outputs decode registered state only, so reset clears them without a clock edge
  always_comb begin
    ram_addr = idx;
    leds     = 4'd0;
    busy     = (state != IDLE);
    done     = (state == DONE);
    if (state == SHOW) begin
      leds = data_reg;
    end
  end

endmodule

// File: tb/tb_seq_player.sv
// tb_seq_player: directed bench for seq_player with HOLD_CYCLES=3, GAP_CYCLES=2.
// A per-cycle expected trace (leds, busy, done, ram_addr) is queued at each start
// and popped at every falling clock edge while the DUT plays.
module tb_seq_player;

  localparam int H = 3;
  localparam int G = 2;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic [3:0] last;
  logic [3:0] ram_addr;
  logic [3:0] ram_q;
  logic [3:0] leds;
  logic       busy;
  logic       done;

  logic [3:0] mem [16];

  typedef struct {
    logic [3:0] leds;
    logic       busy;
    logic       done;
    logic [3:0] addr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  seq_player #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .last     (last),
    .ram_addr (ram_addr),
    .ram_q    (ram_q),
    .leds     (leds),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 16x4 synchronous-read RAM model
  always @(posedge clk) ram_q <= mem[ram_addr];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] l, input logic b, input logic d, input logic [3:0] a);
    exp_t e;
    e.leds = l; e.busy = b; e.done = d; e.addr = a;
    return e;
  endfunction

  // Expected trace from the cycle after the start edge through one idle cycle after done
  task automatic push_play(input logic [3:0] l);
    for (int e = 0; e <= int'(l); e++) begin
      logic [3:0] a;
      a = 4'(e);
      for (int k = 0; k < 2; k++) q.push_back(mk(4'd0, 1'b1, 1'b0, a));
      for (int k = 0; k < H; k++) q.push_back(mk(mem[e], 1'b1, 1'b0, a));
      for (int k = 0; k < G; k++) q.push_back(mk(4'd0, 1'b1, 1'b0, a));
    end
    q.push_back(mk(4'd0, 1'b1, 1'b1, l));
    q.push_back(mk(4'd0, 1'b0, 1'b0, l));
  endtask

  task automatic consume(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL scoreboard_empty observed=0 expected=nonempty");
      end else begin
        e = q.pop_front();
        chk("leds", {4'd0, leds}, {4'd0, e.leds});
        chk("busy", {7'd0, busy}, {7'd0, e.busy});
        chk("done", {7'd0, done}, {7'd0, e.done});
        chk("ram_addr", {4'd0, ram_addr}, {4'd0, e.addr});
      end
    end
  endtask

  task automatic drain();
    consume(q.size());
  endtask

  task automatic kick(input logic [3:0] l);
    @(negedge clk);
    start = 1'b1;
    last  = l;
    push_play(l);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_leds"}, {4'd0, leds}, 8'd0);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_done"}, {7'd0, done}, 8'd0);
  endtask

  initial begin
    rst_n = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    last  = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;

    // Reset takes effect before any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk_idle("reset");
    chk("reset_addr", {4'd0, ram_addr}, 8'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Three entries
    mem[0] = 4'hA; mem[1] = 4'h5; mem[2] = 4'hF;
    kick(4'd2);
    drain();

    // Single entry
    mem[0] = 4'h9;
    kick(4'd0);
    drain();

    // Full table, idx must reach 15 without wrapping
    for (int i = 0; i < 16; i++) mem[i] = 4'(i);
    kick(4'd15);
    drain();

    // start pulse and last change mid-play are ignored
    mem[0] = 4'hA; mem[1] = 4'h5; mem[2] = 4'hF;
    kick(4'd2);
    consume(10);               // cycle 10 is the first SHOW cycle of entry 1
    start = 1'b1;
    last  = 4'd0;
    consume(1);
    start = 1'b0;
    drain();
    repeat (3) begin
      @(negedge clk);
      chk_idle("post_ignore");
    end

    // stop during GAP of entry 0
    kick(4'd0);
    consume(6);                // cycle 6 is the first GAP cycle
    stop = 1'b1;
    q.delete();
    @(posedge clk);
    #1 stop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_idle("after_stop");
    end
    kick(4'd1);
    drain();

    // Asynchronous reset between edges during SHOW
    kick(4'd2);
    consume(4);                // cycle 4 is mid-SHOW of entry 0
    chk("pre_reset_leds", {4'd0, leds}, 8'h0A);
    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    chk("async_reset_addr", {4'd0, ram_addr}, 8'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_idle("after_reset");
    end
    kick(4'd0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
